game_flow_ctrl: RTL

//  Parametrised game-flow controller for the VGA Pong family. It replaces the fixed MENU/GAME/SETTINGS selector.

---
 rtl/game_pkg.sv | 26 ++
 rtl/edge_rise.sv | 22 ++
 rtl/game_flow_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared Pong game constants: state encoding and default score/speed widths
// used by the flow controller, ball, pixel generator and text display.
package game_pkg;

  localparam int GAME_SCORE_W = 4;
  localparam int GAME_SPEED_W = 4;

  typedef enum logic [2:0] {
    ST_MENU      = 3'd0,
    ST_SETTINGS  = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_SERVE     = 3'd4,
    ST_PAUSE     = 3'd5,
    ST_OVER      = 3'd6
  } game_state_e;

  // Bit positions of the buttons in the packed vector fed to edge_rise.
  localparam int BTN_START   = 0;
  localparam int BTN_SETTING = 1;
  localparam int BTN_PAUSE   = 2;
  localparam int BTN_UP      = 3;
  localparam int BTN_DOWN    = 4;
  localparam int BTN_COUNT   = 5;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a bank of debounced button levels; the history
// resets high so a button held through reset does not fire.
module edge_rise #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_level,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= '1;
    else       r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Pong game-flow controller: menu, settings, countdown, play/serve/pause,
// game-over hold, N-player scoring and ball speed selection, paced by frame_tick.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS      = 2,
  parameter int SCORE_W          = game_pkg::GAME_SCORE_W,
  parameter int WIN_SCORE        = 9,
  parameter int SPEED_W          = game_pkg::GAME_SPEED_W,
  parameter int SPEED_MIN        = 1,
  parameter int SPEED_MAX        = 8,
  parameter int SPEED_DEF        = 3,
  parameter int COUNT_FROM       = 3,
  parameter int COUNTDOWN_FRAMES = 60,
  parameter int SERVE_FRAMES     = 60,
  parameter int OVER_FRAMES      = 300,
  localparam int CD_W            = $clog2(COUNT_FROM + 1),
  localparam int PIDX_W          = $clog2(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_frame_tick,
  input  logic                           i_start_btn,
  input  logic                           i_setting_btn,
  input  logic                           i_pause_btn,
  input  logic                           i_up_btn,
  input  logic                           i_down_btn,
  input  logic [NUM_PLAYERS-1:0]         i_point_evt,
  output logic [2:0]                     o_state,
  output logic                           o_game_active,
  output logic                           o_serve_req,
  output logic [CD_W-1:0]                o_countdown,
  output logic [NUM_PLAYERS*SCORE_W-1:0] o_scores,
  output logic [SPEED_W-1:0]             o_ball_speed,
  output logic                           o_game_over,
  output logic [PIDX_W-1:0]              o_winner
);

  localparam int FRAME_MAX_CS = (COUNTDOWN_FRAMES > SERVE_FRAMES) ? COUNTDOWN_FRAMES : SERVE_FRAMES;
  localparam int FRAME_MAX    = (FRAME_MAX_CS > OVER_FRAMES) ? FRAME_MAX_CS : OVER_FRAMES;
  localparam int FRAME_W      = $clog2(FRAME_MAX + 1);

  localparam logic [FRAME_W-1:0] CD_LAST    = FRAME_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [FRAME_W-1:0] SERVE_LAST = FRAME_W'(SERVE_FRAMES - 1);
  localparam logic [FRAME_W-1:0] OVER_LAST  = (OVER_FRAMES == 0) ? '0 : FRAME_W'(OVER_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_SAT  = '1;

  // Button edges
  logic [BTN_COUNT-1:0] w_levels;
  logic [BTN_COUNT-1:0] w_rise;
  logic w_start, w_setting, w_pause, w_up, w_down;

  assign w_levels[BTN_START]   = i_start_btn;
  assign w_levels[BTN_SETTING] = i_setting_btn;
  assign w_levels[BTN_PAUSE]   = i_pause_btn;
  assign w_levels[BTN_UP]      = i_up_btn;
  assign w_levels[BTN_DOWN]    = i_down_btn;

  edge_rise #(.WIDTH(BTN_COUNT)) u_edge_rise (
    .clk     (clk),
    .reset   (reset),
    .i_level (w_levels),
    .o_rise  (w_rise)
  );

  assign w_start   = w_rise[BTN_START];
  assign w_setting = w_rise[BTN_SETTING];
  assign w_pause   = w_rise[BTN_PAUSE];
  assign w_up      = w_rise[BTN_UP];
  assign w_down    = w_rise[BTN_DOWN];

  // Registered state
  game_state_e          r_state;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic [CD_W-1:0]      r_countdown;
  logic [SPEED_W-1:0]   r_speed;
  logic [PIDX_W-1:0]    r_winner;
  logic                 r_serve_req;

  game_state_e          w_next_state;
  logic [FRAME_W-1:0]   w_next_cnt;
  logic [CD_W-1:0]      w_next_cd;
  logic [SPEED_W-1:0]   w_next_speed;
  logic [PIDX_W-1:0]    w_next_winner;
  logic                 w_next_serve;
  logic                 w_score_clr;
  logic                 w_score_inc;

  logic [SCORE_W-1:0]   w_scores [NUM_PLAYERS];
  logic                 w_pt_hit;
  logic [PIDX_W-1:0]    w_pt_idx;
  logic [SCORE_W-1:0]   w_pt_new;

  // Lowest set point bit wins when several players score in the same cycle.
  always_comb begin
    w_pt_hit = 1'b0;
    w_pt_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (i_point_evt[i]) begin
        w_pt_hit = 1'b1;
        w_pt_idx = PIDX_W'(i);
      end
    end
  end

  assign w_pt_new = (w_scores[w_pt_idx] == SCORE_SAT) ? SCORE_SAT : w_scores[w_pt_idx] + 1'b1;

  // NOTE: every combinational output is given a default first, so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = i_frame_tick ? r_frame_cnt + 1'b1 : r_frame_cnt;
    w_next_cd     = r_countdown;
    w_next_speed  = r_speed;
    w_next_winner = r_winner;
    w_next_serve  = 1'b0;
    w_score_clr   = 1'b0;
    w_score_inc   = 1'b0;

    case (r_state)
      ST_MENU: begin
        if (w_start) begin
          w_next_state  = ST_COUNTDOWN;
          w_next_cd     = CD_W'(COUNT_FROM);
          w_next_winner = '0;
          w_score_clr   = 1'b1;
        end else if (w_setting) begin
          w_next_state = ST_SETTINGS;
        end
      end
      ST_SETTINGS: begin
        if (w_up && !w_down && r_speed < SPEED_W'(SPEED_MAX))
          w_next_speed = r_speed + 1'b1;
        else if (w_down && !w_up && r_speed > SPEED_W'(SPEED_MIN))
          w_next_speed = r_speed - 1'b1;
        if (w_setting || w_start)
          w_next_state = ST_MENU;
      end
      ST_COUNTDOWN: begin
        if (i_frame_tick && r_frame_cnt == CD_LAST) begin
          w_next_cnt = '0;
          if (r_countdown <= CD_W'(1)) begin
            w_next_state = ST_PLAY;
            w_next_cd    = '0;
            w_next_serve = 1'b1;
          end else begin
            w_next_cd = r_countdown - 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (w_pt_hit) begin
          w_score_inc = 1'b1;
          if (w_pt_new == SCORE_W'(WIN_SCORE)) begin
            w_next_state  = ST_OVER;
            w_next_winner = w_pt_idx;
          end else begin
            w_next_state = ST_SERVE;
          end
        end else if (w_pause) begin
          w_next_state = ST_PAUSE;
        end
      end
      ST_SERVE: begin
        if (i_frame_tick && r_frame_cnt == SERVE_LAST) begin
          w_next_state = ST_PLAY;
          w_next_serve = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (w_start)      w_next_state = ST_MENU;
        else if (w_pause) w_next_state = ST_PLAY;
      end
      ST_OVER: begin
        if (w_start)
          w_next_state = ST_MENU;
        else if (OVER_FRAMES != 0 && i_frame_tick && r_frame_cnt == OVER_LAST)
          w_next_state = ST_MENU;
      end
      default: w_next_state = ST_MENU;
    endcase

    if (w_next_state != r_state)
      w_next_cnt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_MENU;
      r_frame_cnt <= '0;
      r_countdown <= '0;
      r_speed     <= SPEED_W'(SPEED_DEF);
      r_winner    <= '0;
      r_serve_req <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_frame_cnt <= w_next_cnt;
      r_countdown <= w_next_cd;
      r_speed     <= w_next_speed;
      r_winner    <= w_next_winner;
      r_serve_req <= w_next_serve;
    end
  end

  // Score array: one saturating register per player.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    logic [SCORE_W-1:0] r_score;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        r_score <= '0;
      else if (w_score_clr)
        r_score <= '0;
      else if (w_score_inc && w_pt_idx == PIDX_W'(g))
        r_score <= w_pt_new;
    end

    assign w_scores[g]                    = r_score;
    assign o_scores[g*SCORE_W +: SCORE_W] = r_score;
  end

  assign o_state       = r_state;
  assign o_game_active = (r_state == ST_PLAY);
  assign o_game_over   = (r_state == ST_OVER);
  assign o_serve_req   = r_serve_req;
  assign o_countdown   = r_countdown;
  assign o_ball_speed  = r_speed;
  assign o_winner      = r_winner;

endmodule
